// File: rtl/bcd_down_timer_if.sv
// Control/data bundle for bcd_down_timer: the controller drives the load, start and tick
// strobes; the timer returns its count and its status pulses.
interface bcd_down_timer_if #(
    parameter int DIGITS = 4
);
    logic                  i_sclr;
    logic                  i_load;
    logic [4*DIGITS-1:0]   i_value;
    logic                  i_start;
    logic                  i_pause;
    logic                  i_tick;
    logic [4*DIGITS-1:0]   o_cnt;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_err;

    modport master (
        output i_sclr, i_load, i_value, i_start, i_pause, i_tick,
        input  o_cnt, o_busy, o_done, o_err
    );

    modport slave (
        input  i_sclr, i_load, i_value, i_start, i_pause, i_tick,
        output o_cnt, o_busy, o_done, o_err
    );
endinterface

// File: rtl/bcd_down_timer.sv
// Loadable multi-digit BCD down-counter with a one-cycle expiry pulse.
// The timer can either stop at zero or reload itself from the last loaded value.
module bcd_down_timer #(
    parameter int DIGITS      = 4,
    parameter int MOD         = 10,
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    bcd_down_timer_if.slave  bus
);
    localparam int         W    = 4 * DIGITS;
    localparam logic [3:0] DMAX = 4'(MOD - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state_q;
    logic [W-1:0]    cnt_q;
    logic [W-1:0]    rld_q;
    logic            done_q;
    logic            err_q;

    logic [W-1:0]      dec_cnt;
    logic [W-1:0]      ld_cnt;
    logic [DIGITS-1:0] lo_zero;
    logic [DIGITS-1:0] ill;
    logic              cnt_zero;
    logic              dec_zero;
    logic              qtick;

    // lo_zero[k]: every digit below k is zero, so digit k takes the borrow
    for (genvar k = 0; k < DIGITS; k++) begin : g_dig
        logic [3:0] d;
        logic [3:0] v;
        assign d = cnt_q[4*k +: 4];
        assign v = bus.i_value[4*k +: 4];
        if (k == 0) begin : g_lsd
            assign lo_zero[k] = 1'b1;
        end else begin : g_hi
            assign lo_zero[k] = lo_zero[k-1] & (cnt_q[4*(k-1) +: 4] == 4'd0);
        end
        assign dec_cnt[4*k +: 4] = !lo_zero[k] ? d : ((d == 4'd0) ? DMAX : d - 4'd1);
        assign ill[k]            = ({1'b0, v} >= 5'(MOD));
        assign ld_cnt[4*k +: 4]  = ill[k] ? DMAX : v;
    end

    assign cnt_zero = (cnt_q == '0);
    assign dec_zero = (dec_cnt == '0);
    assign qtick    = bus.i_tick & ~bus.i_pause;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rld_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.i_sclr) begin
                cnt_q   <= '0;
                state_q <= IDLE;
            end else if (bus.i_load) begin
                cnt_q   <= ld_cnt;
                rld_q   <= ld_cnt;
                err_q   <= |ill;
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.i_start) begin
                            if (cnt_zero) done_q  <= 1'b1;
                            else          state_q <= RUN;
                        end
                    end
                    RUN: begin
                        if (qtick) begin
                            if (cnt_zero) begin
                                // Only reachable in periodic mode: the tick after expiry reloads
                                if (AUTO_RELOAD) begin
                                    cnt_q  <= rld_q;
                                    done_q <= (rld_q == '0);
                                end
                            end else begin
                                cnt_q <= dec_cnt;
                                if (dec_zero) begin
                                    done_q <= 1'b1;
                                    if (!AUTO_RELOAD) state_q <= IDLE;
                                end
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.o_cnt  = cnt_q;
    assign bus.o_busy = (state_q == RUN);
    assign bus.o_done = done_q;
    assign bus.o_err  = err_q;
endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench: dut_a stops at zero, dut_b auto-reloads; both see the same stimulus.
module tb_bcd_down_timer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclr = 1'b0, load = 1'b0, start = 1'b0, pause = 1'b0, tick = 1'b0;
    logic [11:0] value = '0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    typedef struct {
        int          cyc;
        logic [11:0] cnt;
        logic        busy;
        logic        done;
        logic        err;
        string       nm;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];

    bcd_down_timer_if #(.DIGITS(3)) ifa ();
    bcd_down_timer_if #(.DIGITS(3)) ifb ();

    assign ifa.i_sclr = sclr;  assign ifb.i_sclr = sclr;
    assign ifa.i_load = load;  assign ifb.i_load = load;
    assign ifa.i_value = value; assign ifb.i_value = value;
    assign ifa.i_start = start; assign ifb.i_start = start;
    assign ifa.i_pause = pause; assign ifb.i_pause = pause;
    assign ifa.i_tick = tick;  assign ifb.i_tick = tick;

    bcd_down_timer #(.DIGITS(3), .MOD(10), .AUTO_RELOAD(1'b0)) dut_a (
        .i_clk(clk), .i_rst(rst), .bus(ifa.slave)
    );
    bcd_down_timer #(.DIGITS(3), .MOD(10), .AUTO_RELOAD(1'b1)) dut_b (
        .i_clk(clk), .i_rst(rst), .bus(ifb.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation stamped for the current cycle
    always @(negedge clk) begin
        exp_t e;
        while (qa.size() > 0 && qa[0].cyc <= cyc) begin
            e = qa.pop_front();
            total++;
            if (e.cyc != cyc || ifa.o_cnt !== e.cnt || ifa.o_busy !== e.busy ||
                ifa.o_done !== e.done || ifa.o_err !== e.err) begin
                bad++;
                $display("FAIL A.%s cyc=%0d: got cnt=%h busy=%b done=%b err=%b want cnt=%h busy=%b done=%b err=%b",
                         e.nm, cyc, ifa.o_cnt, ifa.o_busy, ifa.o_done, ifa.o_err,
                         e.cnt, e.busy, e.done, e.err);
            end
        end
        while (qb.size() > 0 && qb[0].cyc <= cyc) begin
            e = qb.pop_front();
            total++;
            if (e.cyc != cyc || ifb.o_cnt !== e.cnt || ifb.o_busy !== e.busy ||
                ifb.o_done !== e.done || ifb.o_err !== e.err) begin
                bad++;
                $display("FAIL B.%s cyc=%0d: got cnt=%h busy=%b done=%b err=%b want cnt=%h busy=%b done=%b err=%b",
                         e.nm, cyc, ifb.o_cnt, ifb.o_busy, ifb.o_done, ifb.o_err,
                         e.cnt, e.busy, e.done, e.err);
            end
        end
    end

    task automatic push(input int sel, input logic [11:0] ec, input logic eb, ed, ee,
                        input string nm);
        exp_t e;
        e.cyc = cyc; e.cnt = ec; e.busy = eb; e.done = ed; e.err = ee; e.nm = nm;
        if (sel == 1 || sel == 3) qa.push_back(e);
        if (sel == 2 || sel == 3) qb.push_back(e);
    endtask

    // One clock of stimulus; expectation is the state after the edge (sel: 1=A 2=B 3=both 0=none)
    task automatic step(input int sel, input logic sc, ld, input logic [11:0] v,
                        input logic st, pa, tk,
                        input logic [11:0] ec, input logic eb, ed, ee, input string nm);
        @(negedge clk);
        sclr = sc; load = ld; value = v; start = st; pause = pa; tick = tk;
        @(posedge clk);
        #1;
        push(sel, ec, eb, ed, ee, nm);
    endtask

    initial begin
        //    sel sc ld value    st pa tk  cnt      b  d  e
        step(3,  0, 0, 12'h000, 0, 0, 1, 12'h000, 0, 0, 0, "reset");
        rst = 1'b0;
        // stop-at-zero countdown
        step(1,  0, 1, 12'h003, 0, 0, 0, 12'h003, 0, 0, 0, "load3");
        step(1,  0, 0, 12'h000, 1, 0, 0, 12'h003, 1, 0, 0, "start3");
        step(1,  0, 0, 12'h000, 0, 0, 1, 12'h002, 1, 0, 0, "t2");
        step(1,  0, 0, 12'h000, 0, 0, 1, 12'h001, 1, 0, 0, "t1");
        step(1,  0, 0, 12'h000, 0, 0, 1, 12'h000, 0, 1, 0, "t0");
        step(1,  0, 0, 12'h000, 0, 0, 1, 12'h000, 0, 0, 0, "hold0a");
        step(1,  0, 0, 12'h000, 0, 0, 1, 12'h000, 0, 0, 0, "hold0b");
        // borrow and start-at-zero
        step(1,  0, 1, 12'h010, 0, 0, 0, 12'h010, 0, 0, 0, "load10");
        step(1,  0, 0, 12'h000, 1, 0, 0, 12'h010, 1, 0, 0, "start10");
        step(1,  0, 0, 12'h000, 0, 0, 1, 12'h009, 1, 0, 0, "b10");
        step(1,  0, 1, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0, "load0");
        step(1,  0, 0, 12'h000, 1, 0, 0, 12'h000, 0, 1, 0, "startzero");
        step(1,  0, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0, "donegone");
        step(1,  0, 1, 12'h100, 0, 0, 0, 12'h100, 0, 0, 0, "load100");
        step(1,  0, 0, 12'h000, 1, 0, 0, 12'h100, 1, 0, 0, "start100");
        step(1,  0, 0, 12'h000, 0, 0, 1, 12'h099, 1, 0, 0, "b100");
        // priorities and pause
        step(1,  0, 1, 12'h050, 0, 0, 1, 12'h050, 0, 0, 0, "ldtick");
        step(1,  0, 0, 12'h000, 1, 0, 1, 12'h050, 1, 0, 0, "starttick");
        for (int i = 0; i < 5; i++)
            step(1, 0, 0, 12'h000, 0, 1, 1, 12'h050, 1, 0, 0, "pause");
        step(1,  0, 0, 12'h000, 0, 0, 1, 12'h049, 1, 0, 0, "unpause");
        step(1,  1, 1, 12'h077, 0, 0, 1, 12'h000, 0, 0, 0, "sclrld");
        // illegal digits clamp to 9
        step(1,  0, 1, 12'h01C, 0, 0, 0, 12'h019, 0, 0, 1, "clamp1c");
        step(1,  0, 0, 12'h000, 0, 0, 0, 12'h019, 0, 0, 0, "errgone");
        step(1,  0, 1, 12'hA5F, 0, 0, 0, 12'h959, 0, 0, 1, "clampa5f");
        // async reset mid-run
        step(1,  0, 1, 12'h042, 0, 0, 0, 12'h042, 0, 0, 0, "load42");
        step(1,  0, 0, 12'h000, 1, 0, 0, 12'h042, 1, 0, 0, "start42");
        step(1,  0, 0, 12'h000, 0, 0, 1, 12'h041, 1, 0, 0, "t41");
        step(1,  0, 0, 12'h000, 0, 0, 1, 12'h040, 1, 0, 0, "t40");
        step(0,  0, 0, 12'h000, 0, 0, 1, 12'h039, 1, 0, 0, "t39");
        tick = 1'b0;
        #1 rst = 1'b1;
        #1 rst = 1'b0;
        push(3, 12'h000, 0, 0, 0, "arst");
        step(1,  0, 0, 12'h000, 0, 0, 1, 12'h000, 0, 0, 0, "arsttick");
        step(1,  0, 0, 12'h000, 1, 0, 0, 12'h000, 0, 1, 0, "arststart");
        step(1,  0, 1, 12'h005, 0, 0, 0, 12'h005, 0, 0, 0, "load5");
        step(1,  0, 0, 12'h000, 1, 0, 0, 12'h005, 1, 0, 0, "start5");
        step(1,  0, 0, 12'h000, 0, 0, 1, 12'h004, 1, 0, 0, "t4");
        // periodic mode on dut_b
        step(2,  0, 1, 12'h002, 0, 0, 0, 12'h002, 0, 0, 0, "load2");
        step(2,  0, 0, 12'h000, 1, 0, 0, 12'h002, 1, 0, 0, "start2");
        step(2,  0, 0, 12'h000, 0, 0, 1, 12'h001, 1, 0, 0, "p1");
        step(2,  0, 0, 12'h000, 0, 0, 1, 12'h000, 1, 1, 0, "p0");
        step(2,  0, 0, 12'h000, 0, 0, 1, 12'h002, 1, 0, 0, "reload2");
        step(2,  0, 0, 12'h000, 0, 0, 1, 12'h001, 1, 0, 0, "p1b");
        step(2,  0, 0, 12'h000, 0, 1, 1, 12'h001, 1, 0, 0, "pauseexp");
        step(2,  0, 0, 12'h000, 0, 0, 1, 12'h000, 1, 1, 0, "p0b");
        step(2,  0, 0, 12'h000, 0, 0, 1, 12'h002, 1, 0, 0, "reload2b");
        step(2,  1, 1, 12'h077, 0, 0, 1, 12'h000, 0, 0, 0, "sclrrun");
        // clamped reload value is what comes back after expiry
        step(2,  0, 1, 12'h00C, 0, 0, 0, 12'h009, 0, 0, 1, "clampc");
        step(2,  0, 0, 12'h000, 0, 0, 0, 12'h009, 0, 0, 0, "idle9");
        step(2,  0, 0, 12'h000, 1, 0, 0, 12'h009, 1, 0, 0, "start9");
        for (int k = 8; k >= 0; k--)
            step(2, 0, 0, 12'h000, 0, 0, 1, 12'(k), 1, (k == 0), 0, "run9");
        step(2,  0, 0, 12'h000, 0, 0, 1, 12'h009, 1, 0, 0, "rld9");
        step(2,  0, 0, 12'h000, 1, 0, 1, 12'h008, 1, 0, 0, "startinrun");
        step(2,  1, 0, 12'h000, 0, 0, 0, 12'h000, 0, 0, 0, "sclr");

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (qa.size() != 0 || qb.size() != 0) begin
            bad++;
            $display("FAIL drain: pending a=%0d b=%0d want 0", qa.size(), qb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_down_timer.md
# bcd_down_timer

Multi-digit loadable BCD down-counter and countdown timer. It is the decrementing counterpart of the team's BCD up-counters. It counts a loaded decimal value down to zero on qualified ticks and signals expiry with a one-cycle pulse. It sits between a tick source (prescaler or up-counter carry) and control logic that needs decimal timeouts, optionally auto-reloading for periodic events.

## Interface
- DIGITS, 4, number of BCD digits (1..8)
- MOD, 10, per-digit modulus (2..16); digits are 4 bits wide
- AUTO_RELOAD, 0, 1 = restart from reload value after expiry; 0 = stop at zero

Ports:
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_sclr  in  1  synchronous clear: o_cnt <= 0, state IDLE; reload register kept
- i_load  in  1  load i_value into o_cnt and reload register
- i_value  in  4*DIGITS  load value, digit 0 (least significant) in [3:0]
- i_start  in  1  begin counting
- i_pause  in  1  level; holds count while high
- i_tick  in  1  decrement strobe, one decrement per cycle high
- o_cnt  out  4*DIGITS  current count, BCD, digit 0 in [3:0]
- o_busy  out  1  high in RUN
- o_done  out  1  one-cycle expiry pulse
- o_err  out  1  one-cycle pulse: last load contained an illegal digit

## Operation
- Reset (i_rst high, async): o_cnt=0, reload=0, state IDLE, o_busy=0, o_done=0, o_err=0.
- Per-cycle priority: i_rst > i_sclr > i_load > i_start > tick.
- Qualified tick: i_tick=1 and i_pause=0 in state RUN. Ticks in IDLE are ignored.
- States:
  - IDLE: o_busy=0.
    - i_start with o_cnt != 0 -> RUN.
    - i_start with o_cnt == 0 -> o_done pulse; stays IDLE.
  - RUN: o_busy=1. i_start is ignored.
    - A qualified tick decrements o_cnt.
    - If the decrement yields 0: o_done pulse.
      - AUTO_RELOAD=0: -> IDLE.
      - AUTO_RELOAD=1: stay in RUN. The next qualified tick at o_cnt=0 loads the reload value; no o_done on that tick.
    - If the reload value is 0 with AUTO_RELOAD=1: o_done pulses on every qualified tick.
- Load:
  - i_load in any state writes o_cnt and the reload register, forces IDLE, and aborts any run; the cycle's tick is discarded.
  - Any digit >= MOD is clamped to MOD-1 in both registers, and o_err pulses.
- Decrement arithmetic:
  - Digit k decrements when all lower digits were 0 (borrow chain from digit 0).
  - A digit at 0 that receives a borrow becomes MOD-1.
  - The all-zero count never decrements; it reloads or holds.
- i_sclr: o_cnt=0, IDLE, o_done/o_err not asserted.

## Timing
- All outputs are registered, except that reset forces them asynchronously.
- A qualified tick at edge N is reflected in o_cnt after edge N.
- o_done rises after the same edge on which o_cnt first shows 0, for exactly one cycle. o_busy falls on that edge when AUTO_RELOAD=0.
- Start-at-zero: o_done is high for the cycle after the i_start edge.
- Load: o_cnt shows the clamped value one cycle after i_load; o_err is coincident with it.
- Start: i_start at edge N gives o_busy=1 after N; the first decrement is possible at edge N+1.
- Periodic mode period: reload+1 qualified ticks between o_done pulses.
- i_pause is sampled each edge; pausing on the expiring tick suppresses both the decrement and o_done.
- Reset mid-run: outputs clear without waiting for a clock edge. After deassertion the block is IDLE and needs a new load and start.

## Test plan
- DIGITS=2: load 0x03, start, tick every cycle -> o_cnt 0x02, 0x01, 0x00. o_done is high exactly with 0x00. o_busy falls on the same edge. Further ticks leave 0x00.
- Borrow: load 0x10, start, one tick -> 0x09. Load 0x00 then start -> o_done pulse with o_busy staying 0. Load 0x100 (DIGITS=3) and one tick -> 0x099.
- AUTO_RELOAD=1: load 0x02, start, continuous ticks -> 01, 00 (done), 02, 01, 00 (done). Done pulses are 3 ticks apart; o_busy stays 1.
- Illegal load: load 0x1C -> o_cnt 0x19, o_err one cycle. Reload of 0x19 is confirmed by auto-reload.
- Priority: i_load with i_tick in RUN -> new value, IDLE, no decrement. i_sclr with i_load -> o_cnt 0, reload unchanged. i_pause high for 5 ticks -> count frozen, o_busy 1.
- Async reset: load 0x42, start, 3 ticks (0x39). Pulse i_rst between edges -> o_cnt 0 and o_busy 0 before the next edge; ticks ignored until reload and restart.
